fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 16 +
 rtl/skid_buf2.sv | 65 ++++++
 rtl/fifo_reader.sv | 100 ++++++++++
 tb/tb_fifo_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and default widths for the FIFO reader slice.
//   state_t            - reader state machine encoding (IDLE, RUN, DRAIN)
//   DEFAULT_DATA_WIDTH - default word width of FIFO read data / output stream
//   DEFAULT_CNT_WIDTH  - default width of the pop counter
package fifo_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry ordered buffer. entry0 is always the oldest word.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears entries and count)
//   push      - write data_in this edge (ignored when full)
//   data_in   - word to write
//   pop       - discard the oldest word this edge (ignored when empty)
//   data_out  - oldest buffered word
//   count     - number of buffered words, 0..2
module skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic [1:0]       cnt;

  assign data_out = entry0;
  assign count    = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            entry0 <= data_in;
            cnt    <= 2'd1;
          end else if (cnt == 2'd1) begin
            entry1 <= data_in;
            cnt    <= 2'd2;
          end
        end
        2'b01: begin
          if (cnt != 2'd0) begin
            entry0 <= entry1;
            cnt    <= cnt - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy unchanged, the queue shifts.
          if (cnt == 2'd2) begin
            entry0 <= entry1;
            entry1 <= data_in;
          end else begin
            entry0 <= data_in;
            cnt    <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops words from an upstream FIFO with one-cycle read latency
// and presents them on a valid/ready output stream through a 2-entry buffer.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   enable        - permission to issue new pops
//   fifo_empty    - upstream FIFO has no entries
//   fifo_pop      - one-cycle pop strobe to the upstream FIFO
//   fifo_rd_data  - FIFO read data, valid the cycle after a pop
//   m_valid       - m_data holds a word
//   m_ready       - downstream accepts the word
//   m_data        - output word (oldest buffered)
//   busy          - state is not IDLE
//   pop_count     - pops issued since reset, wraps
// Handshake: a word transfers on any edge where m_valid and m_ready are both 1.
// m_valid never depends on m_ready, and m_data is held while m_valid=1 and
// m_ready=0.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  state_t               state;
  logic                 inflight;
  logic [CNT_WIDTH-1:0] pop_cnt;
  logic [1:0]           occ;
  logic                 xfer;
  logic [2:0]           committed;
  logic                 drain_done;

  assign m_valid   = (occ != 2'd0);
  assign xfer      = m_valid & m_ready;
  assign busy      = (state != IDLE);
  assign pop_count = pop_cnt;

  // Words already owned by the reader: buffered plus the one on its way back.
  assign committed = {1'b0, occ} + {2'b00, inflight};

  // Pop only if the word it returns is guaranteed a buffer slot; enable also
  // gates new pops so dropping it stops traffic in the same cycle.
  assign fifo_pop = (state == RUN) && enable && !fifo_empty &&
                    (committed <= (3'd1 + {2'b00, xfer}));

  // Nothing left once the current transfer leaves (no pops occur in DRAIN).
  assign drain_done = !inflight && (occ == {1'b0, xfer});

  skid_buf2 #(
    .WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .data_in  (fifo_rd_data),
    .pop      (xfer),
    .data_out (m_data),
    .count    (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
      pop_cnt  <= '0;
    end else begin
      inflight <= fifo_pop;
      if (fifo_pop) begin
        pop_cnt <= pop_cnt + CNT_WIDTH'(1);
      end
      unique case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state <= (occ == 2'd0 && !inflight) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (enable)          state <= RUN;
          else if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader with an upstream FIFO model
// and a scoreboard of expected output words.
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty = 1'b1;
  logic          fifo_pop;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [CW-1:0] pop_count;

  // Second instance with a 4-bit counter, driven by the same inputs.
  logic          pop4;
  logic          valid4;
  logic [DW-1:0] data4;
  logic          busy4;
  logic [3:0]    cnt4;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit pop_seen = 1'b0;
  int first_pop = -1;
  int first_xfer = -1;
  int last_xfer = -1;
  bit saw_drain = 1'b0;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_pop     (fifo_pop),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .busy         (busy),
    .pop_count    (pop_count)
  );

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_pop     (pop4),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (valid4),
    .m_ready      (m_ready),
    .m_data       (data4),
    .busy         (busy4),
    .pop_count    (cnt4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- upstream FIFO model ----------------
  // A pop seen in cycle N returns its word just after the edge ending N.
  always @(posedge clk) begin
    #1;
    if (pop_seen && fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      pop_seen = 1'b0;
    end else begin
      pop_seen = fifo_pop;
      n_cmp++;
      if (fifo_pop && fifo_empty) begin
        n_err++;
        $display("FAIL pop_on_empty: fifo_pop=1 with fifo_empty=1 at cycle %0d", cyc);
      end
      n_cmp++;
      if (dut.occ > 2'd2) begin
        n_err++;
        $display("FAIL occ_bound: occ=%0d, required <= 2", dut.occ);
      end
      if (dut.state == DRAIN) saw_drain = 1'b1;
      if (fifo_pop && first_pop < 0) first_pop = cyc;
      if (m_valid && m_ready) begin
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got %0d, required no transfer", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_err++;
            $display("FAIL m_data: got %0d, required %0d", m_data, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic load(input int first, input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(DW'(first + i));
      if (expect_out) exp_q.push_back(DW'(first + i));
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    #1;
    // Asynchronous reset values before any clock edge.
    check("rst_fifo_pop", 32'(fifo_pop), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pop_count", 32'(pop_count), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Streaming 1..8 with m_ready held high.
    load(1, 8, 1'b1);
    m_ready = 1'b1;
    tick();
    first_pop = -1;
    first_xfer = -1;
    last_xfer = -1;
    enable = 1'b1;
    wait_drain("stream_outstanding", 60);
    check("stream_latency", 32'(first_xfer - first_pop), 32'd2);
    check("stream_back_to_back", 32'(last_xfer - first_xfer), 32'd7);
    check("stream_pop_count", 32'(pop_count), 32'd8);
    check("stream_busy", 32'(busy), 32'd1);

    // Second round 100..107: counter reaches 16; the 4-bit counter wraps to 0.
    load(100, 8, 1'b1);
    wait_drain("wrap_outstanding", 60);
    check("wrap_pop_count", 32'(pop_count), 32'd16);
    check("wrap_pop_count_cw4", 32'(cnt4), 32'd0);
    check("wrap_m_valid_idle", 32'(m_valid), 32'd0);

    // Reset asserted mid-stream clears everything before the next edge.
    load(1, 8, 1'b1);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_fifo_pop", 32'(fifo_pop), 32'd0);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    check("midrst_pop_count", 32'(pop_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cw4_pop", 32'(pop4), 32'd0);
    check("midrst_cw4_valid", 32'(valid4), 32'd0);
    check("midrst_cw4_data", 32'(data4), 32'd0);
    check("midrst_cw4_busy", 32'(busy4), 32'd0);
    check("midrst_cw4_count", 32'(cnt4), 32'd0);
    enable = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_m_valid", 32'(m_valid), 32'd0);
    check("postrst_pop_count", 32'(pop_count), 32'd0);

    // Backpressure: only two pops while m_ready is low, head word held.
    load(1, 8, 1'b1);
    m_ready = 1'b0;
    enable = 1'b1;
    repeat (10) tick();
    check("bp_pop_count", 32'(pop_count), 32'd2);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    check("bp_m_data", 32'(m_data), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_m_data_hold", 32'(m_data), 32'd1);
    end
    m_ready = 1'b1;
    wait_drain("bp_outstanding", 60);
    check("bp_final_pop_count", 32'(pop_count), 32'd8);

    // Enable drop with one word buffered and one in flight.
    reset_pulse();
    load(1, 6, 1'b0);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    enable = 1'b1;
    for (int n = 0; n < 20 && pop_count != 16'd2; n++) tick();
    check("drop_pre_pop_count", 32'(pop_count), 32'd2);
    check("drop_pre_occ", 32'(dut.occ), 32'd1);
    check("drop_pre_inflight", 32'(dut.inflight), 32'd1);
    saw_drain = 1'b0;
    enable = 1'b0;
    m_ready = 1'b1;
    wait_drain("drop_outstanding", 20);
    check("drop_saw_drain", 32'(saw_drain), 32'd1);
    check("drop_state_idle", 32'(dut.state), 32'(IDLE));
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_pop_count", 32'(pop_count), 32'd2);
    for (int i = 3; i <= 6; i++) exp_q.push_back(DW'(i));
    enable = 1'b1;
    wait_drain("resume_outstanding", 40);
    check("resume_pop_count", 32'(pop_count), 32'd6);

    // Random m_ready over words 0..63.
    reset_pulse();
    load(0, 64, 1'b1);
    enable = 1'b1;
    for (int n = 0; n < 3000 && exp_q.size() != 0; n++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    wait_drain("rand_outstanding", 20);
    check("rand_pop_count", 32'(pop_count), 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
